// File: rtl/win_frame_ctrl_pkg.sv
// Shared constants and types for the Hann-windowed frame controller.
//   WIN_N / WIN_IDX_W : frame length and window index width
//   COEF_W / COEF_FRAC: unsigned Q1.11 coefficient format (2048 = 1.0)
//   state_e           : frame sequencer states
//   pipe_flags_t      : per-sample flags carried down the pipeline
package win_pkg;

    localparam int unsigned WIN_N     = 32;
    localparam int unsigned WIN_IDX_W = 5;
    localparam int unsigned COEF_W    = 12;
    localparam int unsigned COEF_FRAC = 11;
    localparam int unsigned FLUSH_CYC = 2;

    typedef logic [WIN_IDX_W-1:0] win_idx_t;
    typedef logic [COEF_W-1:0]    coef_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } pipe_flags_t;

endpackage

// File: rtl/win_frame_ctrl_if.sv
// Control, sample-in and windowed-sample-out bundle of win_frame_ctrl.
//   master: drives start/stop/cont/in_valid/in_data, observes the outputs
//   slave : the controller side
interface win_frame_ctrl_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 16
);
    logic                     start;
    logic                     stop;
    logic                     cont;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_first;
    logic                     out_last;
    logic                     busy;
    logic [CNT_W-1:0]         frame_cnt;

    modport master (
        output start, stop, cont, in_valid, in_data,
        input  out_valid, out_data, out_first, out_last, busy, frame_cnt
    );

    modport slave (
        input  start, stop, cont, in_valid, in_data,
        output out_valid, out_data, out_first, out_last, busy, frame_cnt
    );
endinterface

// File: rtl/win_frame_ctrl_coef_rom.sv
// 32-point Hann window table, w(k) = round(1024*(1-cos(2*pi*k/32))).
//   clk, rst : clock, async active-high reset
//   idx_i    : window index
//   coef_o   : registered coefficient (one-cycle latency)
module hann_coef_rom
    import win_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  win_idx_t idx_i,
    output coef_t    coef_o
);

    coef_t coef_d;
    coef_t coef_q;

    // Symmetric table, only half is distinct
    always_comb begin
        coef_d = '0;
        case (idx_i)
            5'd0:         coef_d = 12'd0;
            5'd1,  5'd31: coef_d = 12'd20;
            5'd2,  5'd30: coef_d = 12'd78;
            5'd3,  5'd29: coef_d = 12'd173;
            5'd4,  5'd28: coef_d = 12'd300;
            5'd5,  5'd27: coef_d = 12'd455;
            5'd6,  5'd26: coef_d = 12'd632;
            5'd7,  5'd25: coef_d = 12'd824;
            5'd8,  5'd24: coef_d = 12'd1024;
            5'd9,  5'd23: coef_d = 12'd1224;
            5'd10, 5'd22: coef_d = 12'd1416;
            5'd11, 5'd21: coef_d = 12'd1593;
            5'd12, 5'd20: coef_d = 12'd1748;
            5'd13, 5'd19: coef_d = 12'd1875;
            5'd14, 5'd18: coef_d = 12'd1970;
            5'd15, 5'd17: coef_d = 12'd2028;
            5'd16:        coef_d = 12'd2048;
            default:      coef_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) coef_q <= '0;
        else     coef_q <= coef_d;
    end

    assign coef_o = coef_q;

endmodule

// File: rtl/win_frame_ctrl.sv
// Frame sequencer: windows 32-sample frames with a Hann table ahead of the FFT.
//   clk, rst : clock, async active-high reset
//   bus      : start/stop/cont control, sample in, windowed sample out with
//              first/last flags (latency 2), busy and completed-frame count
module win_frame_ctrl
    import win_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    win_frame_ctrl_if.slave bus
);

    localparam int unsigned PROD_W   = DATA_W + COEF_W;
    localparam int unsigned FLUSH_W  = 2;
    localparam win_idx_t    IDX_LAST = WIN_IDX_W'(WIN_N - 1);

    state_e                   state_q, state_d;
    win_idx_t                 idx_q, idx_d;
    logic                     stop_pend_q, stop_pend_d;
    logic [FLUSH_W-1:0]       flush_q, flush_d;
    logic [CNT_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic                     busy_q, busy_d;
    pipe_flags_t              s1_flags_q, s1_flags_d;
    logic signed [DATA_W-1:0] s1_data_q;
    pipe_flags_t              out_flags_q;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    coef_t                    coef_q;
    logic signed [PROD_W-1:0] prod_c;

    logic accept_c;
    logic frame_end_c;
    logic flush_done_c;

    assign accept_c     = (state_q == RUN) && bus.in_valid;
    assign frame_end_c  = accept_c && (idx_q == IDX_LAST);
    assign flush_done_c = (flush_q == FLUSH_W'(FLUSH_CYC - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; a frame is never cut short by stop
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (frame_end_c && !(bus.cont && !stop_pend_q && !bus.stop))
                         state_d = FLUSH;
            FLUSH:   if (flush_done_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer bookkeeping and stage-1 flags
    always_comb begin
        idx_d            = idx_q;
        stop_pend_d      = stop_pend_q;
        frame_cnt_d      = frame_cnt_q;
        flush_d          = '0;
        busy_d           = (state_d != IDLE);
        s1_flags_d.valid = accept_c;
        s1_flags_d.first = accept_c && (idx_q == '0);
        s1_flags_d.last  = frame_end_c;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    idx_d       = '0;
                    frame_cnt_d = '0;
                    stop_pend_d = bus.stop;
                end
            end
            RUN: begin
                if (bus.stop)    stop_pend_d = 1'b1;
                // idx wraps 31 -> 0 on its own at the frame end
                if (accept_c)    idx_d       = idx_q + WIN_IDX_W'(1);
                if (frame_end_c) frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
            FLUSH: begin
                flush_d = flush_q + FLUSH_W'(1);
                if (flush_done_c) stop_pend_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Sample times unsigned Q1.11 coefficient; >>> floors toward -inf
    always_comb begin
        prod_c     = PROD_W'(s1_data_q) * PROD_W'($signed({1'b0, coef_q}));
        out_data_d = s1_flags_q.valid ? DATA_W'(prod_c >>> COEF_FRAC) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            stop_pend_q <= 1'b0;
            flush_q     <= '0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
            s1_flags_q  <= '0;
            s1_data_q   <= '0;
            out_flags_q <= '0;
            out_data_q  <= '0;
        end else begin
            idx_q       <= idx_d;
            stop_pend_q <= stop_pend_d;
            flush_q     <= flush_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
            s1_flags_q  <= s1_flags_d;
            if (accept_c) s1_data_q <= bus.in_data;
            out_flags_q <= s1_flags_q;
            out_data_q  <= out_data_d;
        end
    end

    // Coefficient read lines up with the stage-1 sample register
    hann_coef_rom u_rom (
        .clk    (clk),
        .rst    (rst),
        .idx_i  (idx_q),
        .coef_o (coef_q)
    );

    assign bus.out_valid = out_flags_q.valid;
    assign bus.out_first = out_flags_q.first;
    assign bus.out_last  = out_flags_q.last;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_win_frame_ctrl.sv
// Directed bench for win_frame_ctrl: one 16-bit-counter instance for the
// windowing tests and one 2-bit-counter instance for counter wrap.
module tb_win_frame_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    win_frame_ctrl_if #(.DATA_W(12), .CNT_W(16)) bi ();
    win_frame_ctrl_if #(.DATA_W(12), .CNT_W(2))  bw ();

    win_frame_ctrl #(.DATA_W(12), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bi)
    );

    win_frame_ctrl #(.DATA_W(12), .CNT_W(2)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bw)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // expected and observed output records
    int     exp_cyc[$];
    longint exp_dat[$];
    bit     exp_fst[$];
    bit     exp_lst[$];
    int     obs_cyc[$];
    longint obs_dat[$];
    bit     obs_fst[$];
    bit     obs_lst[$];

    logic signed [11:0] pat[32];
    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    always @(negedge clk) begin
        if (bi.out_valid === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_dat.push_back(longint'(bi.out_data));
            obs_fst.push_back(bi.out_first === 1'b1);
            obs_lst.push_back(bi.out_last === 1'b1);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wref(input int k);
        real c;
        c = 1024.0 * (1.0 - $cos(2.0 * 3.14159265358979 * k / 32.0));
        return longint'($rtoi(c + 0.5));
    endfunction

    function automatic longint win_exp(input longint din, input int k);
        longint p;
        p = din * wref(k);
        return p >>> 11;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic signed [11:0] din, input int k, input bit cons);
        bi.in_valid = 1'b1;
        bi.in_data  = din;
        if (cons) begin
            exp_cyc.push_back(cyc);
            exp_dat.push_back(win_exp(longint'(din), k));
            exp_fst.push_back(k == 0);
            exp_lst.push_back(k == 31);
        end
        tick();
        bi.in_valid = 1'b0;
    endtask

    task automatic start_frame();
        bi.start = 1'b1;
        tick();
        bi.start = 1'b0;
    endtask

    task automatic run_frame(input string tag);
        start_frame();
        for (int k = 0; k < 32; k++) sample(pat[k], k, 1'b1);
        tick();
        tick();
        tick();
        chk($sformatf("%s frame_cnt", tag), longint'(bi.frame_cnt), 1);
        chk($sformatf("%s busy", tag), longint'(bi.busy), 0);
    endtask

    task automatic compare_outputs(input string tag);
        chk($sformatf("%s count", tag), obs_dat.size(), exp_dat.size());
        for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
            chk($sformatf("%s data[%0d]", tag, i), obs_dat[i], exp_dat[i]);
            chk($sformatf("%s latency[%0d]", tag, i), obs_cyc[i] - exp_cyc[i], 2);
            chk($sformatf("%s first[%0d]", tag, i), obs_fst[i], exp_fst[i]);
            chk($sformatf("%s last[%0d]", tag, i), obs_lst[i], exp_lst[i]);
        end
        exp_cyc.delete(); exp_dat.delete(); exp_fst.delete(); exp_lst.delete();
        obs_cyc.delete(); obs_dat.delete(); obs_fst.delete(); obs_lst.delete();
    endtask

    initial begin
        rst = 1'b1;
        bi.start = 1'b0; bi.stop = 1'b0; bi.cont = 1'b0; bi.in_valid = 1'b0; bi.in_data = '0;
        bw.start = 1'b0; bw.stop = 1'b0; bw.cont = 1'b0; bw.in_valid = 1'b0; bw.in_data = '0;
        tick();
        tick();

        // reset state
        chk("rst out_valid", longint'(bi.out_valid), 0);
        chk("rst out_data", longint'(bi.out_data), 0);
        chk("rst out_first", longint'(bi.out_first), 0);
        chk("rst out_last", longint'(bi.out_last), 0);
        chk("rst busy", longint'(bi.busy), 0);
        chk("rst frame_cnt", longint'(bi.frame_cnt), 0);
        chk("rst wrap frame_cnt", longint'(bw.frame_cnt), 0);
        rst = 1'b0;
        tick();

        // single frame of constant 1000
        start_frame();
        chk("sf busy after start", longint'(bi.busy), 1);
        for (int k = 0; k < 32; k++) sample(12'sd1000, k, 1'b1);
        chk("sf frame_cnt", longint'(bi.frame_cnt), 1);
        chk("sf busy flush1", longint'(bi.busy), 1);
        tick();
        chk("sf busy flush2", longint'(bi.busy), 1);
        chk("sf out_last seen", longint'(bi.out_last), 1);
        tick();
        chk("sf busy idle", longint'(bi.busy), 0);
        chk("sf out_valid idle", longint'(bi.out_valid), 0);
        if (obs_dat.size() == 32) begin
            chk("sf hand idx0", obs_dat[0], 0);
            chk("sf hand idx1", obs_dat[1], 9);
            chk("sf hand idx8", obs_dat[8], 500);
            chk("sf hand idx16", obs_dat[16], 1000);
            chk("sf hand idx31", obs_dat[31], 9);
        end
        compare_outputs("sf");

        // arithmetic extremes
        for (int k = 0; k < 32; k++) pat[k] = 12'(k * 97 - 1200);
        pat[0]  = -12'sd2048;
        pat[1]  = 12'sd2047;
        pat[16] = -12'sd2048;
        run_frame("ext1");
        if (obs_dat.size() == 32) begin
            chk("ext -2048@0", obs_dat[0], 0);
            chk("ext 2047@1", obs_dat[1], 19);
            chk("ext -2048@16", obs_dat[16], -2048);
        end
        compare_outputs("ext1");
        pat[1] = -12'sd1;
        run_frame("ext2");
        if (obs_dat.size() == 32) chk("ext -1@1", obs_dat[1], -1);
        compare_outputs("ext2");

        // ignored inputs: IDLE samples, start+in_valid, start in RUN and FLUSH
        for (int k = 0; k < 32; k++) pat[k] = 12'(k * 61 - 900);
        bi.in_valid = 1'b1; bi.in_data = 12'sd777;
        tick(); tick(); tick();
        bi.in_valid = 1'b0;
        bi.start = 1'b1; bi.in_valid = 1'b1; bi.in_data = -12'sd900;
        tick();
        bi.start = 1'b0; bi.in_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            bi.start = (k == 5);
            sample(pat[k], k, 1'b1);
        end
        bi.start = 1'b1; bi.in_valid = 1'b1; bi.in_data = 12'sd333;
        tick();
        bi.start = 1'b0;
        tick();
        bi.in_valid = 1'b0;
        tick(); tick();
        chk("ign busy", longint'(bi.busy), 0);
        chk("ign frame_cnt", longint'(bi.frame_cnt), 1);
        compare_outputs("ign");

        // continuous mode, stop inside frame 2
        bi.cont = 1'b1;
        start_frame();
        for (int i = 0; i < 96; i++) begin
            bi.stop = (i == 37);
            sample(12'(i * 45 - 2000), i % 32, i < 64);
        end
        bi.stop = 1'b0;
        bi.cont = 1'b0;
        tick(); tick(); tick();
        chk("cont frame_cnt", longint'(bi.frame_cnt), 2);
        chk("cont busy", longint'(bi.busy), 0);
        if (obs_dat.size() >= 33) begin
            chk("cont b2b gap", obs_cyc[32] - obs_cyc[31], 1);
            chk("cont b2b last", obs_lst[31], 1);
            chk("cont b2b first", obs_fst[32], 1);
        end
        compare_outputs("cont");

        // reset after sample 10; outputs of samples 9 and 10 must never appear
        start_frame();
        for (int k = 0; k <= 10; k++) sample(12'sd1000, k, k <= 8);
        rst = 1'b1;
        #1;
        chk("mrst out_valid", longint'(bi.out_valid), 0);
        chk("mrst out_data", longint'(bi.out_data), 0);
        chk("mrst out_first", longint'(bi.out_first), 0);
        chk("mrst out_last", longint'(bi.out_last), 0);
        chk("mrst busy", longint'(bi.busy), 0);
        chk("mrst frame_cnt", longint'(bi.frame_cnt), 0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        compare_outputs("mrst");
        for (int k = 0; k < 32; k++) pat[k] = 12'(1500 - k * 50);
        run_frame("restart");
        compare_outputs("restart");

        // 2-bit counter wraps over 5 continuous frames
        bw.cont = 1'b1;
        bw.start = 1'b1;
        tick();
        bw.start = 1'b0;
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 32; k++) begin
                bw.stop     = (f == 4 && k == 3);
                bw.in_valid = 1'b1;
                bw.in_data  = 12'(k);
                tick();
                if (k == 31) chk($sformatf("wrap frame %0d", f), longint'(bw.frame_cnt), wrap_exp[f]);
            end
        end
        bw.in_valid = 1'b0; bw.stop = 1'b0; bw.cont = 1'b0;
        tick(); tick(); tick();
        chk("wrap busy", longint'(bw.busy), 0);
        chk("wrap final cnt", longint'(bw.frame_cnt), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
